// File: rtl/systolic_result_requant.sv
// systolic_result_requant: captures both 4x4 result tiles on done,
// requantizes to OUT_W with round-half-up/saturation, streams row-major.
module systolic_result_requant #(
  parameter int N     = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done,
  input  logic [N*N*IN_W-1:0]   res1_flat,
  input  logic [N*N*IN_W-1:0]   res2_flat,
  input  logic [3:0]            shift1,
  input  logic [3:0]            shift2,
  output logic                  flush_req,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data1,
  output logic [OUT_W-1:0]      out_data2,
  output logic [1:0]            out_row,
  output logic [1:0]            out_col,
  output logic                  out_last,
  output logic                  drop_err,
  output logic [4:0]            sat_cnt
);

  localparam int RW = $clog2(N);
  localparam int IW = $clog2(N*N);
  localparam int BW = N*N*IN_W;

  localparam logic signed [IN_W:0] MAXV =
    (IN_W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [IN_W:0] MINV =
    (IN_W+1)'(-(2**(OUT_W-1)));
  localparam logic [OUT_W-1:0] MAXO =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINO =
    {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, STREAM} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   buf1_q, buf1_d;
  logic [BW-1:0]   buf2_q, buf2_d;
  logic [3:0]      sh1_q, sh1_d;
  logic [3:0]      sh2_q, sh2_d;
  logic            flush_q, flush_d;
  logic            drop_q, drop_d;
  logic [4:0]      sat_q, sat_d;

  logic [IN_W-1:0] el1, el2;
  logic [OUT_W:0]  rq1, rq2;
  logic            last;

  // Returns {saturated, value}; the rounding add is one bit
  // wider than the input so large positives cannot wrap.
  function automatic logic [OUT_W:0] rq(
    input logic [IN_W-1:0] x,
    input logic [3:0]      s
  );
    logic [IN_W:0]        rnd;
    logic signed [IN_W:0] w;
    logic signed [IN_W:0] t;
    rnd = '0;
    if (s != 4'd0) rnd[s-4'd1] = 1'b1;
    w = $signed({x[IN_W-1], x}) + $signed(rnd);
    t = w >>> s;
    if (t > MAXV)      rq = {1'b1, MAXO};
    else if (t < MINV) rq = {1'b1, MINO};
    else               rq = {1'b0, t[OUT_W-1:0]};
  endfunction

  always_comb begin
    el1  = buf1_q[idx_q*IN_W +: IN_W];
    el2  = buf2_q[idx_q*IN_W +: IN_W];
    rq1  = rq(el1, sh1_q);
    rq2  = rq(el2, sh2_q);
    last = (state_q == STREAM) &&
           (idx_q == IW'(N*N-1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf1_d  = buf1_q;
    buf2_d  = buf2_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    flush_d = 1'b0;
    drop_d  = drop_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (done) begin
          buf1_d  = res1_flat;
          buf2_d  = res2_flat;
          sh1_d   = shift1;
          sh2_d   = shift2;
          idx_d   = '0;
          flush_d = 1'b1;
          sat_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (done) drop_d = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + 1'b1;
          sat_d = sat_q + 5'(rq1[OUT_W])
                        + 5'(rq2[OUT_W]);
          if (last) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf1_q  <= '0;
      buf2_q  <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      flush_q <= 1'b0;
      drop_q  <= 1'b0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf1_q  <= buf1_d;
      buf2_q  <= buf2_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      flush_q <= flush_d;
      drop_q  <= drop_d;
      sat_q   <= sat_d;
    end
  end

  assign busy      = (state_q == STREAM);
  assign out_valid = busy;
  assign flush_req = flush_q;
  assign drop_err  = drop_q;
  assign sat_cnt   = sat_q;
  assign out_last  = last;
  assign out_data1 = rq1[OUT_W-1:0];
  assign out_data2 = rq2[OUT_W-1:0];
  assign out_row   = 2'(idx_q[IW-1:RW]);
  assign out_col   = 2'(idx_q[RW-1:0]);

endmodule

// File: tb/tb_systolic_result_requant.sv
// tb_systolic_result_requant: directed vectors for the
// requant/stream stage with hand-computed expectations.
module tb_systolic_result_requant;

  logic         clk = 1'b0;
  logic         reset;
  logic         done;
  logic [255:0] res1_flat;
  logic [255:0] res2_flat;
  logic [3:0]   shift1;
  logic [3:0]   shift2;
  logic         flush_req;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data1;
  logic [7:0]   out_data2;
  logic [1:0]   out_row;
  logic [1:0]   out_col;
  logic         out_last;
  logic         drop_err;
  logic [4:0]   sat_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] r1 [16];
  logic [15:0] r2 [16];
  logic [7:0]  e1 [16];
  logic [7:0]  e2 [16];
  bit          s1 [16];
  bit          s2 [16];

  always #5 clk = ~clk;

  systolic_result_requant dut (
    .clk       (clk),
    .reset     (reset),
    .done      (done),
    .res1_flat (res1_flat),
    .res2_flat (res2_flat),
    .shift1    (shift1),
    .shift2    (shift2),
    .flush_req (flush_req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .drop_err  (drop_err),
    .sat_cnt   (sat_cnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_tile();
    for (int i = 0; i < 16; i++) begin
      r1[i] = '0; r2[i] = '0;
      e1[i] = '0; e2[i] = '0;
      s1[i] = 1'b0; s2[i] = 1'b0;
    end
  endtask

  task automatic drive_tile();
    for (int i = 0; i < 16; i++) begin
      res1_flat[i*16 +: 16] = r1[i];
      res2_flat[i*16 +: 16] = r2[i];
    end
  endtask

  task automatic cap();
    drive_tile();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("cap_flush", 32'(flush_req), 1);
    chk("cap_busy",  32'(busy), 1);
    chk("cap_valid", 32'(out_valid), 1);
  endtask

  // Walks one tile; drop_k >= 0 pulses done at that
  // element and again on the final transfer edge.
  task automatic stream(input bit rnd, input int drop_k);
    int k   = 0;
    int cyc = 0;
    int sb  = 0;
    bit rdy;
    bit dropped = 1'b0;
    while (k < 16 && cyc < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (drop_k >= 0 && k == 15) rdy = 1'b1;
      out_ready = rdy;
      if (drop_k >= 0 && !dropped && k == drop_k) begin
        dropped   = 1'b1;
        res1_flat = ~res1_flat;
        res2_flat = ~res2_flat;
        done      = 1'b1;
      end
      if (drop_k >= 0 && k == 15) done = 1'b1;
      chk("s_valid", 32'(out_valid), 1);
      chk("s_flush", 32'(flush_req), 32'(cyc == 0));
      chk("s_d1",    32'(out_data1), 32'(e1[k]));
      chk("s_d2",    32'(out_data2), 32'(e2[k]));
      chk("s_row",   32'(out_row), 32'(k / 4));
      chk("s_col",   32'(out_col), 32'(k % 4));
      chk("s_last",  32'(out_last), 32'(k == 15));
      chk("s_sat",   32'(sat_cnt), 32'(sb));
      tick();
      done = 1'b0;
      if (rdy) begin
        sb += int'(s1[k]) + int'(s2[k]);
        k++;
      end
      cyc++;
    end
    chk("s_count", 32'(k), 16);
    chk("e_busy",  32'(busy), 0);
    chk("e_valid", 32'(out_valid), 0);
    chk("e_sat",   32'(sat_cnt), 32'(sb));
    chk("e_flush", 32'(flush_req), 0);
    out_ready = 1'b0;
  endtask

  task automatic tile_a();
    clr_tile();
    shift1 = 4'd2; shift2 = 4'd2;
    r1[0] = 16'h0190; e1[0] = 8'h64;
    r1[1] = 16'hFFFA; e1[1] = 8'hFF;
    r1[2] = 16'hFDFF; e1[2] = 8'h80;
    r2[0] = 16'h0007; e2[0] = 8'h02;
    r2[4] = 16'h0200; e2[4] = 8'h7F; s2[4] = 1'b1;
    r2[5] = 16'hFDA8; e2[5] = 8'h80; s2[5] = 1'b1;
    r2[15] = 16'hFFFE; e2[15] = 8'h00;
  endtask

  initial begin
    reset = 1'b0; done = 1'b0; out_ready = 1'b0;
    res1_flat = '0; res2_flat = '0;
    shift1 = '0; shift2 = '0;
    tick();
    chk("rst_busy",  32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flush", 32'(flush_req), 0);
    chk("rst_drop",  32'(drop_err), 0);
    chk("rst_last",  32'(out_last), 0);
    chk("rst_rc",    32'({out_row, out_col}), 0);
    chk("rst_sat",   32'(sat_cnt), 0);
    chk("rst_data",  32'({out_data1, out_data2}), 0);
    reset = 1'b1;
    tick();

    tile_a();
    cap();
    stream(1'b0, -1);
    chk("a_sat2", 32'(sat_cnt), 2);

    // Reset in mid stream after five transfers.
    tile_a();
    cap();
    out_ready = 1'b1;
    repeat (5) tick();
    chk("mid_row", 32'(out_row), 1);
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mr_busy",  32'(busy), 0);
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_rc",    32'({out_row, out_col}), 0);
    chk("mr_sat",   32'(sat_cnt), 0);
    chk("mr_data",  32'({out_data1, out_data2}), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_idle", 32'(busy), 0);
    cap();
    stream(1'b0, -1);

    // Shift 0 passthrough with random backpressure.
    clr_tile();
    shift1 = 4'd0; shift2 = 4'd0;
    r1[0] = 16'h007F; e1[0] = 8'h7F;
    r1[1] = 16'h0080; e1[1] = 8'h7F; s1[1] = 1'b1;
    r1[2] = 16'hFF80; e1[2] = 8'h80;
    r1[3] = 16'hFF7F; e1[3] = 8'h80; s1[3] = 1'b1;
    r2[9] = 16'h0005; e2[9] = 8'h05;
    cap();
    stream(1'b1, -1);
    chk("b_sat2", 32'(sat_cnt), 2);
    chk("b_drop", 32'(drop_err), 0);

    // Wide shifts, rounding without wrap, plus drops.
    clr_tile();
    shift1 = 4'd15; shift2 = 4'd1;
    r1[0] = 16'h7FFF; e1[0] = 8'h01;
    r1[1] = 16'h8000; e1[1] = 8'hFF;
    r2[0] = 16'h0003; e2[0] = 8'h02;
    r2[1] = 16'hFFFD; e2[1] = 8'hFF;
    r2[2] = 16'hFFFF; e2[2] = 8'h00;
    r2[15] = 16'h00FF; e2[15] = 8'h7F; s2[15] = 1'b1;
    cap();
    stream(1'b1, 3);
    chk("d_drop",  32'(drop_err), 1);
    chk("d_sat",   32'(sat_cnt), 1);
    tick();
    chk("d_idle",  32'(busy), 0);
    chk("d_noflush", 32'(flush_req), 0);

    tile_a();
    cap();
    stream(1'b0, -1);
    chk("f_drop", 32'(drop_err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
